wb_scoreboard: RTL and testbench
================================

# wb_scoreboard

Writeback arbiter and register scoreboard placed directly upstream of the 32×32 three-port register file. Merges the single-cycle ALU result stream and a multicycle long-latency unit (load/multiply-divide) into the register file's single write port (`we3`/`wa3`/`wd3`). Tracks registers with outstanding long-latency writes and stalls issue on RAW/WAW hazards against them.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers; register 0 is hardwired to zero.
- `AW`, 5: register address width (log2 `NREG`).
- `DW`, 32: data width.

Ports:
- `clk`, in, 1: rising-edge clock. This is the block's single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `issue_valid`, in, 1: decode presents an instruction.
- `issue_rs1`, `issue_rs2`, in, AW: source registers.
- `issue_rd`, in, AW: destination register.
- `issue_long`, in, 1: destination is written by the long-latency unit.
- `issue_stall`, out, 1: hold decode. Combinational.
- `alu_we`, in, 1: ALU write request. Always accepted.
- `alu_wa`, in, AW: ALU write address.
- `alu_wd`, in, DW: ALU write data.
- `lu_valid`, in, 1: long-unit write request.
- `lu_ready`, out, 1: long-unit write accepted when `lu_valid && lu_ready`.
- `lu_wa`, in, AW: long-unit write address.
- `lu_wd`, in, DW: long-unit write data.
- `we3`, out, 1: registered write enable to the register file.
- `wa3`, out, AW: registered write address.
- `wd3`, out, DW: registered write data.
- `busy`, out, NREG: scoreboard bit vector. Bit 0 is always 0.
- `stall_count`, out, 32: only present with `WB_STATS_EN`.

## Operation
- Write stage W: registers `we3`, `wa3`, `wd3`, plus an internal `w_long` flag.
- Per-edge selection for W, in priority order:
  1. ALU request.
  2. Hold buffer.
  3. Accepted long-unit request.
  4. Idle (`we3`=0).
- Hold buffer: one entry (`hold_v`, addr, data).
  - `lu_ready = !hold_v && !reset`.
  - A long request accepted in a cycle where `alu_we`=1 goes into the hold buffer.
  - Otherwise an accepted long request goes straight to W.
- Any write with address 0 is forced to `we3`=0 and does not touch the scoreboard.
- Scoreboard:
  - Set `busy[issue_rd]` on issue fire (`issue_valid && !issue_stall && issue_long && issue_rd!=0`).
  - Clear `busy[wa3]` on the edge where `we3 && w_long`. This is the same edge the register file commits, so readers in the next cycle see the new value.
- `issue_stall = issue_valid && (busy[rs1] || busy[rs2] || busy[rd])`.
- Set and clear of the same register on the same edge cannot occur, because a WAW stall blocks it. If it is forced, clear wins.
- ALU writes to a busy register are a protocol violation. The block does not check for them.

## Timing
- Reset values: `we3`=0, `wa3`=0, `wd3`=0, `busy`=0, `hold_v`=0, `stall_count`=0, `lu_ready`=0 while `reset` is high.
- ALU path latency: 1 cycle (request at cycle n, `we3` high in cycle n+1).
- Long path latency:
  - 1 cycle if uncontended.
  - Otherwise 1 cycle plus the number of consecutive `alu_we` cycles. The hold buffer waits for the first ALU-idle cycle.
- While `hold_v`=1, `lu_ready`=0. The long unit must hold `lu_valid`/`lu_wa`/`lu_wd` stable until accepted.
- Stall release: `issue_stall` drops in the cycle after the long write's `we3` cycle.
- Reset mid-operation: in-flight hold and W contents are discarded, all busy bits clear. The long unit is reset by the same `reset`.

## Configuration
- `WB_STATS_EN` defined:
  - Adds the `stall_count` output port.
  - Increments each cycle `issue_stall`=1.
  - Saturates at 0xFFFF_FFFF.
  - Cleared by `reset`.
- `WB_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `wb_pkg` holds:
  - `NREG`, `AW`, `DW` constants.
  - Packed write-request typedef `wb_req_t` (`we`, `wa`, `wd`, `is_long`).
- Sub-module `wb_hold_buf`: the one-entry valid/ready buffer for the long path.
- Scoreboard and arbitration stay in the top module.

## Test plan
- ALU write only: `alu_we`=1, `alu_wa`=5, `alu_wd`=0xDEADBEEF in cycle 0 → cycle 1 shows `we3`=1, `wa3`=5, `wd3`=0xDEADBEEF. `busy` stays 0.
- Long issue then RAW:
  - Issue `rd`=7 with `issue_long`=1 → `busy[7]`=1 next cycle.
  - Issue with `rs1`=7 → `issue_stall`=1 until the cycle after `lu_wa`=7 reaches `we3`. Then `issue_stall`=0 and `busy[7]`=0.
- Contention:
  - `alu_we`=1 (wa 3) and `lu_valid`=1 (wa 9, 0x1234) in the same cycle → cycle+1 writes reg 3, `lu_ready`=0.
  - `alu_we`=0 in cycle+1 → cycle+2 writes reg 9 with 0x1234.
- Sustained ALU writes for 4 cycles with the hold buffer full → `lu_ready` stays 0 for 4 cycles. The long write appears on the first idle cycle.
- x0 writes: `alu_wa`=0 or `lu_wa`=0 → `we3`=0. Long issue to `rd`=0 leaves `busy`=0 and `issue_stall`=0.
- Reset mid-operation: assert `reset` with `busy`=0x0000_0080 and `hold_v`=1 → next cycle `busy`=0, `we3`=0, `lu_ready`=1 after `reset` deasserts. With `WB_STATS_EN`, `stall_count`=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and write-request type for the writeback arbiter/scoreboard.
package wb_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          is_long;
  } wb_req_t;

  localparam wb_req_t REQ_IDLE = '{we: 1'b0, wa: {AW{1'b0}}, wd: {DW{1'b0}}, is_long: 1'b0};

  // Register 0 is hardwired to zero, so writes to it are dropped.
  function automatic logic addr_is_x0(input logic [AW-1:0] a);
    return (a == {AW{1'b0}});
  endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry valid/ready buffer that parks a long-unit write while the ALU
// owns the register-file write port.
module wb_hold_buf
  import wb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_wa,
  input  logic [DW-1:0] lu_wd,
  input  logic          alu_we,
  output logic          lu_accept,
  output logic          hold_v,
  output logic [AW-1:0] hold_wa,
  output logic [DW-1:0] hold_wd
);

  logic          hold_v_q,  hold_v_d;
  logic [AW-1:0] hold_wa_q, hold_wa_d;
  logic [DW-1:0] hold_wd_q, hold_wd_d;

  // Handshake and buffer fill/drain: fill when an accepted write collides
  // with the ALU, drain on the first ALU-idle cycle.
  always_comb begin
    lu_ready  = !hold_v_q && !reset;
    lu_accept = lu_valid && lu_ready;
    hold_v_d  = hold_v_q;
    hold_wa_d = hold_wa_q;
    hold_wd_d = hold_wd_q;
    if (hold_v_q) begin
      if (!alu_we) begin
        hold_v_d = 1'b0;
      end else begin
        hold_v_d = 1'b1;
      end
    end else if (lu_accept && alu_we) begin
      hold_v_d  = 1'b1;
      hold_wa_d = lu_wa;
      hold_wd_d = lu_wd;
    end else begin
      hold_v_d = 1'b0;
    end
  end

  // Buffer state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v_q  <= 1'b0;
      hold_wa_q <= {AW{1'b0}};
      hold_wd_q <= {DW{1'b0}};
    end else begin
      hold_v_q  <= hold_v_d;
      hold_wa_q <= hold_wa_d;
      hold_wd_q <= hold_wd_d;
    end
  end

  assign hold_v  = hold_v_q;
  assign hold_wa = hold_wa_q;
  assign hold_wd = hold_wd_q;

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback arbiter and register scoreboard in front of the register file's
// single write port. ALU writes win, then the hold buffer, then a fresh
// long-unit write. Busy bits track outstanding long-latency destinations.
// Optional feature macro: WB_STATS_EN adds a saturating stall_count output.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int NREG = wb_pkg::NREG,
  parameter int AW   = wb_pkg::AW,
  parameter int DW   = wb_pkg::DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_long,
  output logic            issue_stall,
  input  logic            alu_we,
  input  logic [AW-1:0]   alu_wa,
  input  logic [DW-1:0]   alu_wd,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [AW-1:0]   lu_wa,
  input  logic [DW-1:0]   lu_wd,
  output logic            we3,
  output logic [AW-1:0]   wa3,
  output logic [DW-1:0]   wd3,
  output logic [NREG-1:0] busy
`ifdef WB_STATS_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  wb_req_t       w_q, w_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic          lu_accept;
  logic          hold_v;
  logic [AW-1:0] hold_wa;
  logic [DW-1:0] hold_wd;
  logic          issue_fire;

  wb_hold_buf u_hold (
    .clk       (clk),
    .reset     (reset),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_wa     (lu_wa),
    .lu_wd     (lu_wd),
    .alu_we    (alu_we),
    .lu_accept (lu_accept),
    .hold_v    (hold_v),
    .hold_wa   (hold_wa),
    .hold_wd   (hold_wd)
  );

  // Write-port arbitration: ALU, then hold buffer, then direct long write.
  always_comb begin
    w_d = REQ_IDLE;
    if (alu_we) begin
      w_d = '{we: !addr_is_x0(alu_wa), wa: alu_wa, wd: alu_wd, is_long: 1'b0};
    end else if (hold_v) begin
      w_d = '{we: !addr_is_x0(hold_wa), wa: hold_wa, wd: hold_wd, is_long: 1'b1};
    end else if (lu_accept) begin
      w_d = '{we: !addr_is_x0(lu_wa), wa: lu_wa, wd: lu_wd, is_long: 1'b1};
    end else begin
      w_d = REQ_IDLE;
    end
  end

  // Hazard stall against outstanding long writes (RAW on sources, WAW on rd).
  always_comb begin
    issue_stall = issue_valid &&
                  (busy_q[issue_rs1] || busy_q[issue_rs2] || busy_q[issue_rd]);
    issue_fire  = issue_valid && !issue_stall && issue_long && !addr_is_x0(issue_rd);
  end

  // Scoreboard update: set on long issue, clear on long commit; clear wins.
  always_comb begin
    busy_d = busy_q;
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_q;
    end
    if (w_q.we && w_q.is_long) begin
      busy_d[w_q.wa] = 1'b0;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Write stage and scoreboard registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q    <= REQ_IDLE;
      busy_q <= {NREG{1'b0}};
    end else begin
      w_q    <= w_d;
      busy_q <= busy_d;
    end
  end

  assign we3  = w_q.we;
  assign wa3  = w_q.wa;
  assign wd3  = w_q.wd;
  assign busy = busy_q;

`ifdef WB_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;

  // Saturating count of stalled issue cycles.
  always_comb begin
    if (issue_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed testbench for wb_scoreboard with hand-computed expectations.
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_long;
  logic        issue_stall;
  logic        alu_we;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] busy;
`ifdef WB_STATS_EN
  logic [31:0] stall_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_long  (issue_long),
    .issue_stall (issue_stall),
    .alu_we      (alu_we),
    .alu_wa      (alu_wa),
    .alu_wd      (alu_wd),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_wa       (lu_wa),
    .lu_wd       (lu_wd),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .busy        (busy)
`ifdef WB_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0; issue_long = 1'b0;
    alu_we = 1'b0; alu_wa = 5'd0; alu_wd = 32'd0;
    lu_valid = 1'b0; lu_wa = 5'd0; lu_wd = 32'd0;
    step(); step();
    #1;
    check_eq("rst_lu_ready", lu_ready, 0);
    check_eq("rst_we3", we3, 0);
    check_eq("rst_wa3", wa3, 0);
    check_eq("rst_wd3", wd3, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_lu_ready", lu_ready, 1);

    // ALU write only
    step();
    alu_we = 1'b1; alu_wa = 5'd5; alu_wd = 32'hDEADBEEF;
    step();
    alu_we = 1'b0;
    #1;
    check_eq("alu_we3", we3, 1);
    check_eq("alu_wa3", wa3, 5);
    check_eq("alu_wd3", wd3, 32'hDEADBEEF);
    check_eq("alu_busy", busy, 0);
    step();
    check_eq("alu_idle_we3", we3, 0);

    // Long issue to r7, then RAW on r7
    issue_valid = 1'b1; issue_rd = 5'd7; issue_long = 1'b1; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
    #1;
    check_eq("long_issue_nostall", issue_stall, 0);
    step();
    issue_rs1 = 5'd7; issue_rd = 5'd8; issue_long = 1'b0;
    #1;
    check_eq("long_busy7", busy, 32'h0000_0080);
    check_eq("raw_stall_a", issue_stall, 1);
    step();
    lu_valid = 1'b1; lu_wa = 5'd7; lu_wd = 32'h0000_CAFE;
    #1;
    check_eq("raw_stall_b", issue_stall, 1);
    check_eq("lu_ready_free", lu_ready, 1);
    step();
    lu_valid = 1'b0;
    #1;
    check_eq("long_we3", we3, 1);
    check_eq("long_wa3", wa3, 7);
    check_eq("long_wd3", wd3, 32'h0000_CAFE);
    check_eq("raw_stall_wcycle", issue_stall, 1);
    step();
    check_eq("release_busy", busy, 0);
    check_eq("release_stall", issue_stall, 0);
    issue_valid = 1'b0;

    // Contention: ALU and long unit in the same cycle
    alu_we = 1'b1; alu_wa = 5'd3; alu_wd = 32'h0000_0033;
    lu_valid = 1'b1; lu_wa = 5'd9; lu_wd = 32'h0000_1234;
    #1;
    check_eq("cont_lu_ready", lu_ready, 1);
    step();
    alu_we = 1'b0; lu_valid = 1'b0;
    #1;
    check_eq("cont_alu_wa3", wa3, 3);
    check_eq("cont_alu_we3", we3, 1);
    check_eq("cont_lu_ready_held", lu_ready, 0);
    step();
    check_eq("cont_long_we3", we3, 1);
    check_eq("cont_long_wa3", wa3, 9);
    check_eq("cont_long_wd3", wd3, 32'h0000_1234);
    check_eq("cont_lu_ready_back", lu_ready, 1);

    // Sustained ALU traffic with the hold buffer full
    alu_we = 1'b1; alu_wa = 5'd10; alu_wd = 32'h0000_00AA;
    lu_valid = 1'b1; lu_wa = 5'd11; lu_wd = 32'h0000_00BB;
    step();
    lu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_wa = 5'(12 + i);
      #1;
      check_eq("sus_lu_ready", lu_ready, 0);
      step();
      check_eq("sus_alu_wa3", wa3, 64'(12 + i));
    end
    alu_we = 1'b0;
    #1;
    check_eq("sus_lu_ready_last", lu_ready, 0);
    step();
    check_eq("sus_long_we3", we3, 1);
    check_eq("sus_long_wa3", wa3, 11);
    check_eq("sus_long_wd3", wd3, 32'h0000_00BB);
    check_eq("sus_lu_ready_free", lu_ready, 1);

    // Writes and long issue to x0
    alu_we = 1'b1; alu_wa = 5'd0; alu_wd = 32'h1;
    step();
    alu_we = 1'b0;
    check_eq("x0_alu_we3", we3, 0);
    lu_valid = 1'b1; lu_wa = 5'd0; lu_wd = 32'h2;
    step();
    lu_valid = 1'b0;
    check_eq("x0_lu_we3", we3, 0);
    issue_valid = 1'b1; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_long = 1'b1;
    #1;
    check_eq("x0_issue_stall", issue_stall, 0);
    step();
    issue_valid = 1'b0;
    check_eq("x0_busy", busy, 0);

    // Reset mid-operation with r7 busy and hold buffer occupied
    issue_valid = 1'b1; issue_rd = 5'd7; issue_long = 1'b1;
    step();
    issue_rd = 5'd7; issue_rs1 = 5'd0; issue_long = 1'b0;
    #1;
    check_eq("waw_stall", issue_stall, 1);
    issue_valid = 1'b0;
    alu_we = 1'b1; alu_wa = 5'd4; alu_wd = 32'h4;
    lu_valid = 1'b1; lu_wa = 5'd20; lu_wd = 32'h5;
    step();
    lu_valid = 1'b0;
    #1;
    check_eq("pre_rst_busy", busy, 32'h0000_0080);
    check_eq("pre_rst_hold", lu_ready, 0);
    reset = 1'b1; alu_we = 1'b0;
    step();
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_we3", we3, 0);
    check_eq("mid_rst_lu_ready", lu_ready, 0);
`ifdef WB_STATS_EN
    check_eq("mid_rst_stall_count", stall_count, 0);
`endif
    reset = 1'b0;
    #1;
    check_eq("after_rst_lu_ready", lu_ready, 1);
    step();
    check_eq("after_rst_hold_dropped", we3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
